aes_key_schedule: RTL and testbench
===================================

# aes_key_schedule

Iterative AES-128 key expansion unit that sits directly upstream of the AES decryption core. On `start` it expands a 128-bit cipher key into the 11 round keys of FIPS-197 (one round key per clock) and holds them in an internal table. The decryption core then reads them by index, typically 10 down to 0. Expansion runs once per key change, so a fixed key can serve any number of decryptions.

## Interface
Parameters:
- None. AES-128 only: Nk=4, Nr=10.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request expansion of `key`; sampled on the rising edge.
- `key`  input  128  cipher key; bit 127 is byte 0 in FIPS-197 order. Sampled only on the accepted `start` edge.
- `busy`  output  1  high while expansion is in progress.
- `done`  output  1  one-cycle pulse when the table is complete.
- `ready`  output  1  level; high while the table holds a complete, valid schedule.
- `rd_idx`  input  4  round-key index, 0..10.
- `rd_key`  output  128  registered round key for `rd_idx`.

## Operation
- Storage: `rk[0..10]`, each 128 bits. Word w0 is bits [127:96].
- State machine:
  - IDLE. In this state `start` is accepted: `rk[0]<=key`, `rnd<=1`, `rcon<=8'h01`, `busy<=1`, `ready<=0`, and the state moves to RUN.
  - RUN. Each edge computes `rk[rnd]` from `rk[rnd-1]` and increments `rnd`.
  - When `rnd==10` is written: `busy<=0`, `done<=1`, `ready<=1`, and the state returns to IDLE.
- Round function, with prev = w0..w3:
  - t = SubWord(RotWord(w3)) XOR {rcon,24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - RotWord is a left byte rotation. SubWord is four forward S-box lookups, combinational within the cycle.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36. It is produced by xtime: rcon<<1, then ^8'h1b if bit 7 was set. A 10-entry constant is also acceptable.
- `start` while `busy`: ignored. The running expansion is not disturbed and the `key` change is not sampled.
- `start` in IDLE while `ready=1`: accepted. `ready` drops on that edge and the old schedule is overwritten.
- Read port: `rd_key <= (rd_idx<=10) ? rk[rd_idx] : 128'h0` on every edge, regardless of `ready`.
  - Reading while `busy` returns the current partial contents. Consumers must gate on `ready`.

## Timing
- Reset values: `busy=0`, `done=0`, `ready=0`, `rd_key=0`, all `rk` = 0, `rnd=0`, state IDLE.
- Reset takes priority over `start` in the same cycle.
- Reset mid-expansion aborts immediately. The partial table is cleared and no `done` is produced.
- Latency:
  - `start` accepted at edge E0.
  - `rk[k]` is written at edge Ek.
  - `done` and `ready` are high after E10, i.e. 10 cycles after acceptance.
  - `busy` is high from after E0 through E10.
- `done` stays high for exactly one cycle. `ready` stays high until the next accepted `start` or `rst`.
- A back-to-back `start` on the cycle `done` is high is accepted: it is IDLE, so `ready` falls at that edge.
- Throughput: one expansion per 11 cycles minimum.
- Read latency: one cycle. `rd_idx` presented before edge N appears on `rd_key` after edge N.
- A read of `rk[10]` on the edge following `done` returns the final key.

## Test plan
- Reset: hold `rst` for 2 cycles. Required: `busy`, `done`, `ready` all 0, and `rd_key`=0 for `rd_idx`=0..10.
- FIPS-197 C.1 key 000102030405060708090a0b0c0d0e0f, `start` for one cycle. Required:
  - `done` pulses exactly 10 cycles after acceptance.
  - `rk[1]`=d6aa74fdd2af72fadaa678f1d6ab76fe.
  - `rk[10]`=13111d7fe3944a17f307a78b4d2b30c5.
  - `rk[0]` equals the key.
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c. Required:
  - `rk[1]`=a0fafe1788542cb123a339392a6c7605.
  - `rk[10]`=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Reading `rd_idx`=10 down to 0 returns each key one cycle after its index.
- `start` with a different key at cycle 5 of an expansion: ignored. `done` still comes at cycle 10, and the table matches the first key.
- `rst` asserted at cycle 4 of an expansion: no `done`, `ready`=0, table cleared. A new `start` afterwards produces the correct C.1 schedule.
- `rd_idx`=11..15 returns 0. A re-`start` with `ready`=1 drops `ready` on the accept edge and re-asserts it 10 cycles later with the new table.

Source files
------------

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry table,
// with a registered read port for the downstream decryption core.
module aes_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic         ready,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    state_t         stateNext;
    logic           accept;
    logic [3:0]     rnd;
    logic [7:0]     rcon;
    logic [127:0]   rk [0:10];
    logic [127:0]   prevKey;
    logic [127:0]   nextKey;
    logic [127:0]   readKey;
    logic [31:0]    t;
    logic [31:0]    n0, n1, n2, n3;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gfMul(sq, sq);
            inv = gfMul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (rnd == 4'd10) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        prevKey = '0;
        readKey = '0;
        for (int i = 0; i < 10; i++) begin
            if (rnd == 4'(i + 1)) prevKey = rk[i];
        end
        for (int i = 0; i < 11; i++) begin
            if (rd_idx == 4'(i)) readKey = rk[i];
        end
    end

    always_comb begin
        t  = subWord({prevKey[23:0], prevKey[31:24]}) ^ {rcon, 24'h0};
        n0 = prevKey[127:96] ^ t;
        n1 = prevKey[95:64]  ^ n0;
        n2 = prevKey[63:32]  ^ n1;
        n3 = prevKey[31:0]   ^ n2;
        nextKey = {n0, n1, n2, n3};
    end

    // Table writes and status flags; start while busy never reaches here since accept is IDLE-only
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            ready  <= 1'b0;
            rnd    <= 4'd0;
            rcon   <= 8'h00;
            rd_key <= '0;
            for (int i = 0; i < 11; i++) rk[i] <= '0;
        end else begin
            done   <= 1'b0;
            rd_key <= readKey;
            if (accept) begin
                rk[0] <= key;
                rnd   <= 4'd1;
                rcon  <= 8'h01;
                busy  <= 1'b1;
                ready <= 1'b0;
            end else if (state == RUN) begin
                for (int i = 1; i < 11; i++) begin
                    if (rnd == 4'(i)) rk[i] <= nextKey;
                end
                rnd  <= rnd + 4'd1;
                rcon <= xtime(rcon);
                if (rnd == 4'd10) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    ready <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using the FIPS-197 A.1 and C.1 key vectors.
module tb_aes_key_schedule;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic         ready;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int checks = 0;
    int errors = 0;

    logic [127:0] a1Keys [0:10];
    logic [127:0] c1Key, c1Rk1, c1Rk10;

    aes_key_schedule dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .key    (key),
        .busy   (busy),
        .done   (done),
        .ready  (ready),
        .rd_idx (rd_idx),
        .rd_key (rd_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [127:0] k);
        start = 1'b1;
        key   = k;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = -1;
        for (int n = 1; n <= 15; n++) begin
            tick();
            if (done) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic readKey(input logic [3:0] idx, output logic [127:0] val);
        rd_idx = idx;
        tick();
        val = rd_key;
    endtask

    initial begin
        int           cycles;
        int           doneSeen;
        logic [127:0] val;

        a1Keys = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                   128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
                   128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
                   128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
                   128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
                   128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        c1Key  = 128'h000102030405060708090a0b0c0d0e0f;
        c1Rk1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        c1Rk10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        rst    = 1'b1;
        start  = 1'b0;
        key    = '0;
        rd_idx = 4'd0;
        tick();
        tick();
        checkOutput("reset_busy",  128'(busy),  128'd0);
        checkOutput("reset_done",  128'(done),  128'd0);
        checkOutput("reset_ready", 128'(ready), 128'd0);
        rst = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            readKey(4'(i), val);
            checkOutput($sformatf("reset_rk%0d", i), val, 128'd0);
        end

        // C.1 key: latency, single-cycle done, first and last round keys
        applyStimulus(c1Key);
        checkOutput("c1_busy_after_accept", 128'(busy), 128'd1);
        waitDone(cycles);
        checkOutput("c1_done_latency", 128'(cycles), 128'd10);
        checkOutput("c1_busy_at_done", 128'(busy),  128'd0);
        checkOutput("c1_ready_at_done", 128'(ready), 128'd1);
        rd_idx = 4'd10;
        tick();
        checkOutput("c1_done_one_cycle", 128'(done), 128'd0);
        checkOutput("c1_rk10_after_done", rd_key, c1Rk10);
        readKey(4'd1, val);
        checkOutput("c1_rk1", val, c1Rk1);
        readKey(4'd0, val);
        checkOutput("c1_rk0", val, c1Key);

        // A.1 key, read back 10 down to 0
        applyStimulus(a1Keys[0]);
        waitDone(cycles);
        checkOutput("a1_done_latency", 128'(cycles), 128'd10);
        for (int i = 10; i >= 0; i--) begin
            readKey(4'(i), val);
            checkOutput($sformatf("a1_rk%0d", i), val, a1Keys[i]);
        end

        // start with another key mid-expansion must be ignored
        applyStimulus(c1Key);
        for (int i = 0; i < 4; i++) tick();
        applyStimulus(a1Keys[0]);
        waitDone(cycles);
        checkOutput("ignore_done_latency", 128'(cycles + 5), 128'd10);
        readKey(4'd10, val);
        checkOutput("ignore_rk10", val, c1Rk10);
        readKey(4'd0, val);
        checkOutput("ignore_rk0", val, c1Key);

        // reset during expansion aborts and clears the table
        applyStimulus(a1Keys[0]);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy",  128'(busy),  128'd0);
        checkOutput("abort_ready", 128'(ready), 128'd0);
        doneSeen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) doneSeen++;
        end
        checkOutput("abort_no_done", 128'(doneSeen), 128'd0);
        readKey(4'd0, val);
        checkOutput("abort_rk0", val, 128'd0);
        readKey(4'd1, val);
        checkOutput("abort_rk1", val, 128'd0);
        applyStimulus(c1Key);
        waitDone(cycles);
        checkOutput("after_abort_latency", 128'(cycles), 128'd10);
        readKey(4'd1, val);
        checkOutput("after_abort_rk1", val, c1Rk1);
        readKey(4'd10, val);
        checkOutput("after_abort_rk10", val, c1Rk10);

        // out-of-range indices read as zero
        for (int i = 11; i <= 15; i++) begin
            readKey(4'(i), val);
            checkOutput($sformatf("oor_idx%0d", i), val, 128'd0);
        end

        // back-to-back restart on the done cycle while ready
        applyStimulus(a1Keys[0]);
        waitDone(cycles);
        applyStimulus(c1Key);
        checkOutput("restart_ready_drop", 128'(ready), 128'd0);
        waitDone(cycles);
        checkOutput("restart_latency", 128'(cycles), 128'd10);
        checkOutput("restart_ready", 128'(ready), 128'd1);
        readKey(4'd10, val);
        checkOutput("restart_rk10", val, c1Rk10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
